// File: rtl/node_link_rx.sv
// node_link_rx: NoC node inbound link receiver.
// Byte-serial packets in, 32-bit packet FIFO out.
module node_link_rx #(
  parameter int         DEPTH   = 4,
  parameter logic [3:0] NODE_ID = 4'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        put_inbound,
  input  logic [7:0]  payload_inbound,
  output logic        free_inbound,
  output logic [31:0] pkt_out,
  output logic        pkt_out_valid,
  input  logic        pkt_out_ready,
  output logic        proto_err,
  output logic        misroute
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, RX1, RX2, RX3, DROP
  } state_t;

  state_t          state;
  logic [7:0]      b0, b1, b2;
  logic [1:0]      dcnt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     mem [DEPTH];
  logic            reserved;
  logic            enq, deq;

  assign reserved = (state == RX1) ||
                    (state == RX2) ||
                    (state == RX3);

  // Space check counts the slot held by a
  // packet still being reassembled.
  assign free_inbound =
    (int'(count) + int'(reserved)) < DEPTH;

  assign pkt_out_valid = (count != '0);
  assign pkt_out = pkt_out_valid ?
                   mem[rd_ptr] : '0;

  assign enq = (state == RX3) && put_inbound;
  assign deq = pkt_out_valid && pkt_out_ready;

  // Link FSM: reassembly, drop and error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      b0        <= '0;
      b1        <= '0;
      b2        <= '0;
      dcnt      <= '0;
      proto_err <= 1'b0;
      misroute  <= 1'b0;
    end else begin
      misroute <= enq &&
                  (b0[3:0] != NODE_ID);
      case (state)
        IDLE: begin
          if (put_inbound) begin
            if (free_inbound) begin
              b0    <= payload_inbound;
              state <= RX1;
            end else begin
              proto_err <= 1'b1;
              dcnt      <= '0;
              state     <= DROP;
            end
          end
        end
        RX1: begin
          if (put_inbound) begin
            b1    <= payload_inbound;
            state <= RX2;
          end else begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end
        end
        RX2: begin
          if (put_inbound) begin
            b2    <= payload_inbound;
            state <= RX3;
          end else begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end
        end
        RX3: begin
          if (!put_inbound)
            proto_err <= 1'b1;
          state <= IDLE;
        end
        DROP: begin
          if (!put_inbound)
            state <= IDLE;
          else if (dcnt == 2'd2)
            state <= IDLE;
          else
            dcnt <= dcnt + 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Packet storage; contents need no reset.
  always_ff @(posedge clock) begin
    if (enq)
      mem[wr_ptr] <= {b0, b1, b2,
                      payload_inbound};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ?
                  '0 : wr_ptr + AW'(1);
      if (deq)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ?
                  '0 : rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
